tiny_fpga: RTL and testbench
============================

Name: tiny_fpga

Overview:
- Minimal bitstream-programmable logic fabric for a TinyTapeout tile.
- Eight logic elements (LEs), each with a 4-input LUT, per-input source muxes and an optional output flip-flop.
- Configuration is loaded serially through a 264-bit shift chain.
- Fabric inputs come from ui_in. LE outputs drive uo_out.

Parameters:
- N_LE, 8, number of logic elements; fixed and equal to the uo_out width.
- CFG_BITS_PER_LE, 33, configuration bits per LE.

Ports:
- clk  input  1  system clock; all state is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  tile enable; when 0, all state holds.
- ui_in  input  8  fabric primary inputs, sources 0-7.
- uo_out  output  8  uo_out[k] = LE k output.
- uio_in  input  8  [0] = cfg_en, [1] = cfg_data; [7:2] ignored.
- uio_out  output  8  [2] = cfg_tail (chain readback); all other bits 0.
- uio_oe  output  8  constant 8'h04.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0): config chain cleared to all 0 and all LE flip-flops cleared to 0, immediately and asynchronously.
  - With an all-zero chain every LUT outputs 0, so uo_out=0 and uio_out=0. uio_oe=8'h04 at all times.
- Config chain cfg[263:0]:
  - On a clk rising edge with ena=1 and cfg_en=1: cfg <= {cfg[262:0], cfg_data}.
  - The first bit shifted in lands at cfg[263] after 264 shifts.
  - cfg_tail = cfg[263]. This allows readback, and two tiles can be daisy-chained.
- LE k field, with base b = 33k:
  - cfg[b+15:b] = LUT truth table T.
  - cfg[b+19:b+16] = sel0; cfg[b+23:b+20] = sel1; cfg[b+27:b+24] = sel2; cfg[b+31:b+28] = sel3.
  - cfg[b+32] = reg_en.
- Source select value s:
  - 0-7 select ui_in[s].
  - 8-15 select LE (s-8) output, i.e. the value driven onto the fabric net, not uo_out gating.
- LUT evaluation: in_j = source(sel_j); comb = T[{in3,in2,in1,in0}].
- LE flip-flop: on a clk edge with ena=1 and cfg_en=0, ff <= comb. Otherwise it holds, including throughout configuration.
- LE output: reg_en ? ff : comb.
- uo_out[k]: LE k output when cfg_en=0; forced to 0 while cfg_en=1, so no partially loaded logic is visible.
- Combinational feedback loops (reg_en=0 path feeding back to itself) are illegal configurations. Behaviour is undefined and the bench must not generate them.
- ena=0 freezes both the chain and the flip-flops. Combinational outputs still follow ui_in.
- cfg_en asserted mid-run: flip-flops freeze at their current values and resume from those values after cfg_en drops.
- Reset mid-configuration: the chain is fully cleared; a reload starts from bit 0.
- No latency other than the flip-flop stage: the combinational path from ui_in to uo_out is zero-cycle. Registered LEs update one edge after their inputs change.

Test Plan:
- Reset: hold rst_n=0 with random ui_in -> uo_out=8'h00, uio_out=8'h00, uio_oe=8'h04.
- Buffer: program LE0 with T=16'hAAAA, sel0-3=0, reg_en=0, all other LEs zero, then drop cfg_en. ui_in=8'h01 -> uo_out=8'h01; ui_in=8'h00 -> uo_out=8'h00.
- AND4: program LE1 with T=16'h8000, sel0..3=0,1,2,3, reg_en=0. ui_in=8'h0F -> uo_out[1]=1; ui_in=8'h0E -> uo_out[1]=0.
- Toggle flop: program LE2 with T=16'h5555, sel0=10 (LE2 feedback), reg_en=1. After cfg_en=0, uo_out[2] reads 0,1,0,1 on successive edges. Raising cfg_en forces uo_out=0 and freezes the flop; lowering cfg_en resumes from the frozen value.
- Readback: shift a 264-bit pattern P, then shift 264 zeros -> uio_out[2] emits P, first-shifted bit first, during the second 264 cycles.
- Reset mid-load: assert rst_n after 100 shifts -> cfg_tail=0 and uo_out=0. A fresh full load of the buffer configuration works as in the Buffer scenario.

Source files
------------

// File: rtl/tiny_fpga.sv
// tiny_fpga: eight-LE bitstream-programmable logic fabric for a TinyTapeout tile.
// Each LE has a 4-input LUT, four 4-bit source selects and an optional output
// flip-flop. Configuration is loaded serially through a 264-bit shift chain whose
// tail is exposed on uio_out[2] for readback or daisy-chaining.
module tiny_fpga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned N_LE            = 8;
  localparam int unsigned CFG_BITS_PER_LE = 33;
  localparam int unsigned CFG_BITS        = N_LE * CFG_BITS_PER_LE;

  logic                cfg_en;
  logic                cfg_data;
  logic                cfg_tail;
  logic [CFG_BITS-1:0] cfg;
  logic [N_LE-1:0]     ff;
  logic [N_LE-1:0]     reg_en;
  logic [N_LE-1:0]     comb;
  logic [N_LE-1:0]     net;
  logic [N_LE-1:0]     nxt;
  logic [N_LE-1:0]     le_out;
  logic                unused_uio;

  assign cfg_en     = uio_in[0];
  assign cfg_data   = uio_in[1];
  assign unused_uio = &{1'b0, uio_in[7:2]};
  assign cfg_tail   = cfg[CFG_BITS-1];

  assign uio_out = {5'b0, cfg_tail, 2'b0};
  assign uio_oe  = 8'h04;
  assign uo_out  = cfg_en ? '0 : le_out;

  // One LE's LUT: select four sources from {fabric nets, ui_in}, index the truth table.
  function automatic logic lut_eval(input logic [32:0] f, input logic [7:0] ui,
                                    input logic [7:0] fab);
    logic [15:0] src;
    logic [3:0]  idx;
    src = {fab, ui};
    idx = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      idx[j] = src[f[16 + 4*j +: 4]];
    end
    return f[idx];
  endfunction

  // Per-LE output-register enable bits pulled out of the chain.
  always_comb begin
    reg_en = '0;
    for (int unsigned k = 0; k < N_LE; k++) begin
      reg_en[k] = cfg[k*CFG_BITS_PER_LE + 32];
    end
  end

  // Fabric evaluation. The LE-to-LE routing would form a structural loop, so it is
  // unrolled into N_LE relaxation passes starting from the registered values; any
  // legal (loop-free) configuration has comb depth <= N_LE and settles exactly.
  always_comb begin
    net    = reg_en & ff;
    nxt    = '0;
    comb   = '0;
    le_out = '0;
    for (int unsigned p = 0; p < N_LE; p++) begin
      for (int unsigned k = 0; k < N_LE; k++) begin
        nxt[k] = reg_en[k] ? ff[k]
                           : lut_eval(cfg[k*CFG_BITS_PER_LE +: CFG_BITS_PER_LE], ui_in, net);
      end
      net = nxt;
    end
    for (int unsigned k = 0; k < N_LE; k++) begin
      comb[k]   = lut_eval(cfg[k*CFG_BITS_PER_LE +: CFG_BITS_PER_LE], ui_in, net);
      le_out[k] = reg_en[k] ? ff[k] : comb[k];
    end
  end

  // Configuration shift chain: first bit shifted in ends up at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (ena && cfg_en) begin
      cfg <= {cfg[CFG_BITS-2:0], cfg_data};
    end
  end

  // LE flip-flops: capture LUT outputs only in run mode, frozen while configuring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else if (ena && !cfg_en) begin
      ff <= comb;
    end
  end

endmodule

// File: tb/tb_tiny_fpga.sv
// tb_tiny_fpga: scoreboard bench for the tiny_fpga fabric. Inputs are driven on the
// falling clock edge and outputs sampled 1 ns later, away from the rising edge.
module tb_tiny_fpga;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [7:0]   ui_in;
  logic [7:0]   uo_out;
  logic [7:0]   uio_in;
  logic [7:0]   uio_out;
  logic [7:0]   uio_oe;

  int           total = 0;
  int           bad   = 0;
  string        tag_q[$];
  logic [7:0]   exp_q[$];
  logic [263:0] cfg_vec;
  logic [263:0] pat;

  tiny_fpga dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [7:0] obs);
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 8'(exp_q.size()), 8'd1);
    end else begin
      check_val(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Push the expected uo_out, let combinational logic settle, then compare.
  task automatic expect_uo(input string tag, input logic [7:0] v);
    sb_push(tag, v);
    #1;
    sb_pop(uo_out);
  endtask

  function automatic logic [32:0] le_field(input logic [15:0] t, input logic [3:0] s0,
                                           input logic [3:0] s1, input logic [3:0] s2,
                                           input logic [3:0] s3, input logic r);
    return {r, s3, s2, s1, s0, t};
  endfunction

  task automatic set_le(input int k, input logic [32:0] f);
    cfg_vec[k*33 +: 33] = f;
  endtask

  // Called at a falling edge; returns at a falling edge with all 264 bits shifted
  // and cfg_en still high.
  task automatic load(input logic [263:0] v);
    for (int i = 263; i >= 0; i--) begin
      uio_in = {6'b0, v[i], 1'b1};
      if (i == 263) expect_uo("cfg_force", 8'h00);
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    uio_in = 8'h00;
    #2;
    rst_n  = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'($urandom);

    // Reset state
    #1;
    expect_uo("rst_uo", 8'h00);
    check_val("rst_uio_out", uio_out, 8'h00);
    check_val("rst_uio_oe", uio_oe, 8'h04);
    ui_in = 8'($urandom);
    expect_uo("rst_uo2", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Buffer: LE0 = ui_in[0]
    cfg_vec = '0;
    set_le(0, le_field(16'hAAAA, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0));
    ui_in = 8'h01;
    load(cfg_vec);
    uio_in = 8'h00;
    expect_uo("buf_1", 8'h01);
    ui_in = 8'h00;
    expect_uo("buf_0", 8'h00);

    // AND4 on LE1 alongside the LE0 buffer
    pulse_reset();
    set_le(1, le_field(16'h8000, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0));
    load(cfg_vec);
    uio_in = 8'h00;
    ui_in = 8'h0F; expect_uo("and_0f", 8'h03);
    ui_in = 8'h0E; expect_uo("and_0e", 8'h00);
    ui_in = 8'h07; expect_uo("and_07", 8'h01);
    ui_in = 8'h08; expect_uo("and_08", 8'h00);

    // Toggle flop on LE2
    pulse_reset();
    cfg_vec = '0;
    set_le(2, le_field(16'h5555, 4'd10, 4'd0, 4'd0, 4'd0, 1'b1));
    ui_in = 8'h00;
    load(cfg_vec);
    uio_in = 8'h00;
    expect_uo("tog_0", 8'h00);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      expect_uo($sformatf("tog_%0d", i), (i % 2 == 1) ? 8'h04 : 8'h00);
    end
    // Reconfigure mid-run: flop holds its value (1) through the reload
    load(cfg_vec);
    uio_in = 8'h00;
    expect_uo("tog_resume", 8'h04);
    @(negedge clk); expect_uo("tog_r1", 8'h00);
    @(negedge clk); expect_uo("tog_r2", 8'h04);
    ena = 1'b0;
    @(negedge clk); expect_uo("tog_ena0a", 8'h04);
    @(negedge clk); expect_uo("tog_ena0b", 8'h04);
    ena = 1'b1;
    @(negedge clk); expect_uo("tog_ena1", 8'h00);

    // LE-to-LE routing: LE3 = ui[1], LE4 = ~LE3 (comb), LE5 = registered LE4
    pulse_reset();
    cfg_vec = '0;
    set_le(3, le_field(16'hAAAA, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0));
    set_le(4, le_field(16'h5555, 4'd11, 4'd0, 4'd0, 4'd0, 1'b0));
    set_le(5, le_field(16'hAAAA, 4'd12, 4'd0, 4'd0, 4'd0, 1'b1));
    ui_in = 8'h02;
    load(cfg_vec);
    uio_in = 8'h00;
    expect_uo("chn_a", 8'h08);
    @(negedge clk); expect_uo("chn_b", 8'h08);
    ui_in = 8'h00; expect_uo("chn_c", 8'h10);
    @(negedge clk); expect_uo("chn_d", 8'h30);
    ena = 1'b0;
    ui_in = 8'h02; expect_uo("chn_ena0_comb", 8'h28);
    @(negedge clk); expect_uo("chn_ena0_hold", 8'h28);
    ena = 1'b1;
    @(negedge clk); expect_uo("chn_ena1", 8'h08);

    // Readback: load a random pattern, then shift zeros and watch the tail
    pulse_reset();
    for (int i = 0; i < 264; i++) pat[i] = 1'($urandom_range(0, 1));
    load(pat);
    for (int j = 0; j < 264; j++) begin
      uio_in = 8'h01;
      if (j == 100) begin
        ena = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ena = 1'b1;
      end
      sb_push($sformatf("rb_%0d", j), {5'b0, pat[263-j], 2'b0});
      #1;
      sb_pop(uio_out);
      @(negedge clk);
    end
    uio_in = 8'h00;

    // Reset in the middle of a load of all-ones
    pulse_reset();
    for (int i = 0; i < 100; i++) begin
      uio_in = 8'h03;
      @(negedge clk);
    end
    rst_n  = 1'b0;
    uio_in = 8'h00;
    ui_in  = 8'($urandom);
    sb_push("rml_tail", 8'h00);
    #1;
    sb_pop(uio_out);
    expect_uo("rml_uo", 8'h00);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    ui_in = 8'($urandom);
    @(negedge clk);
    expect_uo("rml_post", 8'h00);
    cfg_vec = '0;
    set_le(0, le_field(16'hAAAA, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0));
    ui_in = 8'h00;
    load(cfg_vec);
    uio_in = 8'h00;
    ui_in = 8'h01; expect_uo("rml_buf_1", 8'h01);
    ui_in = 8'h00; expect_uo("rml_buf_0", 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
